// File: rtl/imem_dmem_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the instruction/data RAM arbiter.
//   DEF_ADDR_W : default word-address width
//   STARVE_W   : width of the starvation counter
//   OWN_*      : encoding of which port owns the read response in flight
package mem_arb_pkg;
    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned STARVE_W   = 4;
    localparam logic [1:0]  OWN_NONE   = 2'b00;
    localparam logic [1:0]  OWN_I      = 2'b01;
    localparam logic [1:0]  OWN_D      = 2'b10;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch port, data port and RAM port of the arbiter.
//   master : requester/RAM side (drives requests and mem_rdata)
//   slave  : arbiter side (drives grants, responses and RAM controls)
interface imem_dmem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic [3:0]        d_wmask;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  i_req, i_addr, d_req, d_wmask, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wmask, mem_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_wmask, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_arbiter_pick.sv
// mem_arb_pick: D-priority grant logic with a starvation counter that forces I.
//   clk, resetn    : clock, async active-low reset
//   i_req, d_req   : requests
//   i_gnt, d_gnt   : same-cycle grants (never both high, low in reset)
//   force_i        : I is being forced past a pending D this cycle
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt,
    output logic force_i
);
    logic [STARVE_W-1:0] starve_q, starve_d;
    assign force_i = i_req & d_req & (starve_q == STARVE_W'(STARVE_MAX));
    assign d_gnt   = resetn & d_req & ~force_i;
    assign i_gnt   = resetn & i_req & ~d_gnt;
    // Count consecutive D wins over a waiting I; any I grant or I idle clears it.
    assign starve_d = (!i_req || i_gnt) ? '0 :
                      (d_gnt && starve_q != STARVE_W'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port synchronous RAM between fetch and data.
//   clk, resetn : clock, async active-low reset
//   bus         : fetch/data request ports and RAM port (slave modport)
//   n_conflict  : cycles with both requests high
//   n_starve    : forced fetch grants
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               resetn,
    imem_dmem_arbiter_if.slave bus,
    output logic [31:0]        n_conflict,
    output logic [31:0]        n_starve
);
    logic              force_i;
    logic [1:0]        owner_q, owner_d;
    logic [31:0]       i_hold_q, d_hold_q, conflict_q, starved_q;
    logic [ADDR_W-1:0] addr_d;
    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .resetn  (resetn),
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .i_gnt   (bus.i_gnt),
        .d_gnt   (bus.d_gnt),
        .force_i (force_i)
    );
    assign addr_d        = bus.d_gnt ? bus.d_addr : bus.i_addr;
    assign bus.mem_en    = bus.i_gnt | bus.d_gnt;
    assign bus.mem_addr  = addr_d;
    assign bus.mem_wmask = bus.d_gnt ? bus.d_wmask : 4'd0;
    assign bus.mem_wdata = bus.d_gnt ? bus.d_wdata : 32'd0;
    // Only reads leave a response in flight; writes and idle cycles own nothing.
    assign owner_d = bus.i_gnt ? OWN_I :
                     (bus.d_gnt && bus.d_wmask == 4'd0) ? OWN_D : OWN_NONE;
    // RAM data is shown straight through on the response cycle, then held.
    assign bus.i_rvalid = owner_q == OWN_I;
    assign bus.d_rvalid = owner_q == OWN_D;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : i_hold_q;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : d_hold_q;
    assign n_conflict   = conflict_q;
    assign n_starve     = starved_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q    <= OWN_NONE;
            i_hold_q   <= '0;
            d_hold_q   <= '0;
            conflict_q <= '0;
            starved_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            i_hold_q   <= bus.i_rvalid ? bus.mem_rdata : i_hold_q;
            d_hold_q   <= bus.d_rvalid ? bus.mem_rdata : d_hold_q;
            conflict_q <= conflict_q + {31'd0, bus.i_req & bus.d_req};
            starved_q  <= starved_q + {31'd0, force_i};
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed and random checks of the arbiter against a behavioural model.
module tb_imem_dmem_arbiter;
    localparam int AW   = 14;
    localparam int SMAX = 3;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b1;
    logic [31:0] n_conflict, n_starve;
    int          errors = 0;
    int          checks = 0;
    imem_dmem_arbiter_if #(.ADDR_W(AW)) bus ();
    imem_dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .n_conflict (n_conflict),
        .n_starve   (n_starve)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] init_word(input int k);
        return k == 'h30 ? 32'h1122_3344 : k == 'h40 ? 32'h5555_AAAA : 32'hA000_0000 + 32'(k);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // RAM seen by the DUT
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
        end else if (bus.mem_en) begin
            if (bus.mem_wmask != 4'd0) ram[bus.mem_addr[7:0]] <= merge(ram[bus.mem_addr[7:0]], bus.mem_wdata, bus.mem_wmask);
            else bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end
    // Behavioural model: D wins unless I has already been passed over SMAX times in a row.
    int          passed;
    logic        m_force, e_dg, e_ig, m_iv, m_dv;
    logic [31:0] m_id, m_dd, m_conf, m_starve;
    logic [31:0] mdl_mem [256];
    assign m_force = bus.i_req & bus.d_req & (passed == SMAX);
    assign e_dg    = resetn & bus.d_req & ~m_force;
    assign e_ig    = resetn & bus.i_req & ~e_dg;
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) mdl_mem[k] <= init_word(k);
        end else if (e_dg && bus.d_wmask != 4'd0) begin
            mdl_mem[bus.d_addr[7:0]] <= merge(mdl_mem[bus.d_addr[7:0]], bus.d_wdata, bus.d_wmask);
        end
    end
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            passed <= 0; m_iv <= 0; m_dv <= 0; m_id <= 0; m_dd <= 0; m_conf <= 0; m_starve <= 0;
        end else begin
            passed   <= (bus.i_req && e_dg) ? passed + 1 : 0;
            m_iv     <= e_ig;
            m_dv     <= e_dg && bus.d_wmask == 4'd0;
            if (e_ig) m_id <= mdl_mem[bus.i_addr[7:0]];
            if (e_dg && bus.d_wmask == 4'd0) m_dd <= mdl_mem[bus.d_addr[7:0]];
            m_conf   <= m_conf + 32'(bus.i_req && bus.d_req);
            m_starve <= m_starve + 32'(m_force);
        end
    end
    always @(negedge clk) begin
        if (!load) begin
            chk("i_gnt", 32'(bus.i_gnt), 32'(e_ig));
            chk("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
            chk("mem_en", 32'(bus.mem_en), 32'(e_ig | e_dg));
            chk("mem_wmask", 32'(bus.mem_wmask), e_dg ? 32'(bus.d_wmask) : 32'd0);
            if (e_ig || e_dg) chk("mem_addr", 32'(bus.mem_addr), e_dg ? 32'(bus.d_addr) : 32'(bus.i_addr));
            if (e_dg && bus.d_wmask != 4'd0) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
            chk("i_rvalid", 32'(bus.i_rvalid), 32'(m_iv));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_dv));
            chk("i_rdata", bus.i_rdata, m_id);
            chk("d_rdata", bus.d_rdata, m_dd);
            chk("n_conflict", n_conflict, m_conf);
            chk("n_starve", n_starve, m_starve);
        end
    end
    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic [3:0] dm, input logic [AW-1:0] da, input logic [31:0] dw);
        @(posedge clk);
        #1;
        bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_wmask = dm; bus.d_addr = da; bus.d_wdata = dw;
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] pat;
        pat = 8'b0111_0111;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wmask = '0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1; load = 0;
        // Reset asserted while a fetch response is on the bus
        drive(1, 'h10, 0, 0, 0, 0);
        chk("rst_pre_gnt", 32'(bus.i_gnt), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_pre_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("rst_pre_rdata", bus.i_rdata, 32'hA000_0010);
        #2;
        bus.i_req = 1;
        resetn = 0;
        #1;
        chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_n_conflict", n_conflict, 32'd0);
        chk("rst_n_starve", n_starve, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1; bus.i_req = 0;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("post_rst_rdata", bus.i_rdata, 32'd0);
        // Fetch-only stream, full throughput
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, AW'('h10 + k), 0, 0, 0, 0);
            chk("ionly_gnt", 32'(bus.i_gnt), 32'(k < 4));
            if (k > 0) begin
                chk("ionly_rvalid", 32'(bus.i_rvalid), 32'd1);
                chk("ionly_rdata", bus.i_rdata, 32'hA000_0010 + 32'(k - 1));
            end
        end
        // D wins a conflict
        drive(1, 'h14, 1, 0, 'h20, 0);
        chk("dprio_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("dprio_i_gnt", 32'(bus.i_gnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("dprio_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("dprio_d_rdata", bus.d_rdata, 32'hA000_0020);
        chk("dprio_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("dprio_n_conflict", n_conflict, 32'd1);
        // Starvation bound: D,D,D,I repeating
        for (int k = 0; k < 8; k++) begin
            drive(1, 'h15, 1, 0, AW'('h21 + k), 0);
            chk("starve_d_gnt", 32'(bus.d_gnt), 32'(pat[k]));
            chk("starve_i_gnt", 32'(bus.i_gnt), 32'(!pat[k]));
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("starve_n_starve", n_starve, 32'd2);
        chk("starve_n_conflict", n_conflict, 32'd9);
        // Byte write then read-back
        drive(0, 0, 1, 4'b0100, 'h30, 32'h00AB_0000);
        chk("bw_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("bw_mem_wmask", 32'(bus.mem_wmask), 32'h4);
        drive(0, 0, 1, 0, 'h30, 0);
        chk("bw_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("bw_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("bw_rdata", bus.d_rdata, 32'h11AB_3344);
        // Load data holds across fetch-only cycles
        drive(0, 0, 1, 0, 'h40, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, AW'('h16 + k), 0, 0, 0, 0);
            chk("hold_d_rvalid", 32'(bus.d_rvalid), 32'(k == 0));
            chk("hold_d_rdata", bus.d_rdata, 32'h5555_AAAA);
        end
        // Random traffic, checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), AW'('h10 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0, AW'('h10 + $urandom_range(0, 15)), $urandom);
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
